ripple_freq_meter: RTL and testbench

Frequency and edge-rate meter. It counts rising edges of an asynchronous input (typically a divided clock from a ripple-divider chain) over a programmable gate window of system-clock cycles. It reports the count once per window with a one-cycle valid pulse. It sits on the consuming end of the team's clock-divider blocks and is used to measure and check divider outputs in silicon.

---
 rtl/freq_meter_pkg.sv | 27 ++
 rtl/sync_edge_det.sv | 37 +++
 rtl/ripple_freq_meter.sv | 150 +++++++++++++++
 tb/tb_ripple_freq_meter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// freq_meter_pkg
// Shared definitions for the ripple-divider frequency meter and the blocks
// that reuse its synchronizer/edge detector.
//   fsm_state_t     : measurement controller states
//   PRIME_CYCLES    : settle time for the default synchronizer depth
//   prime_cycles()  : settle time for any synchronizer depth
// ---------------------------------------------------------------------------
package freq_meter_pkg;

   typedef enum logic [1:0] {
      ST_PRIME   = 2'd0,
      ST_IDLE    = 2'd1,
      ST_MEASURE = 2'd2
   } fsm_state_t;

   localparam int DEF_SYNC_STAGES = 2;

   // The synchronizer plus the previous-sample flop must be flushed before
   // any edge can be trusted after reset.
   function automatic int prime_cycles(input int sync_stages);
      return sync_stages + 1;
   endfunction

   localparam int PRIME_CYCLES = DEF_SYNC_STAGES + 1;

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Multi-flop synchronizer for an asynchronous level followed by a
// rising-edge detector (one previous-sample flop).
//   clk        : system clock
//   rst        : synchronous, active-high reset (clears every flop)
//   sig_in     : asynchronous input
//   edge_det   : one-cycle pulse on a synchronized rising edge
//   sync_level : synchronized level of sig_in
// ---------------------------------------------------------------------------
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic edge_det,
   output logic sync_level
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_level = sync_q[SYNC_STAGES-1];
   assign edge_det   = sync_level & ~prev_q;

endmodule

// File: rtl/ripple_freq_meter.sv
// ---------------------------------------------------------------------------
// ripple_freq_meter
// Counts rising edges of an asynchronous input over a programmable gate
// window of clk cycles and reports the count once per window.
//   clk         : system clock
//   rst         : synchronous, active-high reset
//   en          : measurement enable (level)
//   sig_in      : asynchronous signal under measurement
//   gate_len    : window length in clk cycles, sampled at window start
//                 (0 behaves as 1)
//   count_out   : edge count of the last completed window (saturating)
//   count_valid : one-cycle pulse when count_out/overflow update
//   overflow    : last completed window saturated
//   busy        : high while measuring
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_PRIME   | flushing synchronizer after reset; edges and en ignored
// ST_IDLE    | waiting for en; loads gate window on en
// ST_MEASURE | gate counting down, edges accumulated; reload on final cycle
//            | when en stays high, abort to idle when en drops early
// ---------------------------------------------------------------------------
module ripple_freq_meter
   import freq_meter_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int GATE_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sig_in,
   input  logic [GATE_W-1:0] gate_len,
   output logic [CNT_W-1:0]  count_out,
   output logic              count_valid,
   output logic              overflow,
   output logic              busy
);

   localparam int                 PRIME_LEN  = prime_cycles(SYNC_STAGES);
   localparam int                 PRIME_W    = $clog2(PRIME_LEN);
   localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(PRIME_LEN - 1);
   localparam logic [PRIME_W-1:0] PRIME_ONE  = PRIME_W'(1);
   localparam logic [GATE_W-1:0]  GATE_ONE   = GATE_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

   fsm_state_t         state_q;
   logic [PRIME_W-1:0] prime_cnt_q;
   logic [GATE_W-1:0]  gate_cnt_q;
   logic [CNT_W-1:0]   edge_cnt_q;
   logic               ovf_q;

   logic               edge_det;
   logic               sync_level;
   logic               count_edge;
   logic [GATE_W-1:0]  gate_load;
   logic               final_cyc;
   logic               cnt_at_max;
   logic [CNT_W-1:0]   edge_cnt_nxt;
   logic               ovf_nxt;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge_det (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in),
      .edge_det   (edge_det),
      .sync_level (sync_level)
   );

   // A detected edge always coincides with a settled high level; counting
   // against both keeps the count tied to the synchronized waveform.
   assign count_edge = edge_det & sync_level;

   assign gate_load  = (gate_len == '0) ? GATE_ONE : gate_len;
   assign final_cyc  = (gate_cnt_q == GATE_ONE);
   assign cnt_at_max = (edge_cnt_q == CNT_MAX);

   // Saturating accumulate including this cycle's edge; the overflow flag
   // latches any increment attempted while already at max.
   assign edge_cnt_nxt = (count_edge && !cnt_at_max) ? (edge_cnt_q + CNT_ONE)
                                                     : edge_cnt_q;
   assign ovf_nxt      = ovf_q | (count_edge & cnt_at_max);

   assign busy = (state_q == ST_MEASURE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_PRIME;
         prime_cnt_q <= PRIME_LOAD;
         gate_cnt_q  <= '0;
         edge_cnt_q  <= '0;
         ovf_q       <= 1'b0;
         count_out   <= '0;
         overflow    <= 1'b0;
         count_valid <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         case (state_q)
            ST_PRIME: begin
               if (prime_cnt_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  prime_cnt_q <= prime_cnt_q - PRIME_ONE;
               end
            end

            ST_IDLE: begin
               if (en) begin
                  gate_cnt_q <= gate_load;
                  edge_cnt_q <= '0;
                  ovf_q      <= 1'b0;
                  state_q    <= ST_MEASURE;
               end
            end

            ST_MEASURE: begin
               if (final_cyc) begin
                  // Final-cycle edge belongs to this window; reload in the
                  // same cycle so back-to-back windows have no gap.
                  count_out   <= edge_cnt_nxt;
                  overflow    <= ovf_nxt;
                  count_valid <= 1'b1;
                  gate_cnt_q  <= gate_load;
                  edge_cnt_q  <= '0;
                  ovf_q       <= 1'b0;
                  if (!en) begin
                     state_q <= ST_IDLE;
                  end
               end else if (!en) begin
                  // Abort: partial count is dropped, outputs keep last result.
                  state_q <= ST_IDLE;
               end else begin
                  gate_cnt_q <= gate_cnt_q - GATE_ONE;
                  edge_cnt_q <= edge_cnt_nxt;
                  ovf_q      <= ovf_nxt;
               end
            end

            default: begin
               state_q <= ST_PRIME;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ripple_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_ripple_freq_meter
// Self-checking bench for ripple_freq_meter: directed scenarios plus random
// traffic, compared every cycle against a window/edge-history reference.
// ---------------------------------------------------------------------------
module tb_ripple_freq_meter;

   localparam int CNT_W       = 8;
   localparam int GATE_W      = 16;
   localparam int SYNC_STAGES = 2;
   localparam int PRIME       = SYNC_STAGES + 1;
   localparam int CMAX        = (1 << CNT_W) - 1;
   localparam int MAXC        = 16384;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              sig_in;
   logic [GATE_W-1:0] gate_len;
   logic [CNT_W-1:0]  count_out;
   logic              count_valid;
   logic              overflow;
   logic              busy;

   ripple_freq_meter #(
      .CNT_W       (CNT_W),
      .GATE_W      (GATE_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .sig_in      (sig_in),
      .gate_len    (gate_len),
      .count_out   (count_out),
      .count_valid (count_valid),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Edge history: the effective sampled level per cycle (reset forces 0),
   // and a detection that lands SYNC_STAGES cycles after a sampled rise.
   // Windows are tracked as (start cycle, length); the expected count is the
   // number of detections inside the window, saturated.
   typedef enum {M_PRIME, M_IDLE, M_WIN} mmode_t;

   bit               lvl_hist [MAXC];
   bit               det_hist [MAXC];
   int               cyc = 0;
   mmode_t           mmode = M_PRIME;
   int               prime_left = 0;
   int               win_start = 0;
   int               win_len = 0;
   logic [CNT_W-1:0] exp_count = '0;
   logic             exp_valid = 1'b0;
   logic             exp_ovf = 1'b0;
   logic             exp_busy = 1'b0;
   bit               model_live = 1'b0;

   always @(posedge clk) begin
      int c;
      int n;
      c = cyc;
      if (c < MAXC) begin
         lvl_hist[c] = rst ? 1'b0 : sig_in;
         det_hist[c] = (c >= SYNC_STAGES + 1) ?
                       (lvl_hist[c-SYNC_STAGES] & ~lvl_hist[c-SYNC_STAGES-1]) : 1'b0;
      end
      exp_valid = 1'b0;
      if (rst) begin
         mmode      = M_PRIME;
         prime_left = PRIME;
         exp_count  = '0;
         exp_ovf    = 1'b0;
         model_live = 1'b1;
      end else begin
         case (mmode)
            M_PRIME: begin
               prime_left--;
               if (prime_left == 0) mmode = M_IDLE;
            end
            M_IDLE: begin
               if (en) begin
                  win_start = c + 1;
                  win_len   = (gate_len == 0) ? 1 : int'(gate_len);
                  mmode     = M_WIN;
               end
            end
            M_WIN: begin
               if (c == win_start + win_len - 1) begin
                  n = 0;
                  for (int k = win_start; k <= c; k++) n += int'(det_hist[k]);
                  exp_count = (n > CMAX) ? CNT_W'(CMAX) : CNT_W'(n);
                  exp_ovf   = (n > CMAX);
                  exp_valid = 1'b1;
                  if (en) begin
                     win_start = c + 1;
                     win_len   = (gate_len == 0) ? 1 : int'(gate_len);
                  end else begin
                     mmode = M_IDLE;
                  end
               end else if (!en) begin
                  mmode = M_IDLE;
               end
            end
            default: mmode = M_PRIME;
         endcase
      end
      exp_busy = (mmode == M_WIN);
      cyc++;
   end

   always @(negedge clk) begin
      if (model_live) begin
         check_val("count_valid", count_valid, exp_valid);
         check_val("count_out",   count_out,   exp_count);
         check_val("overflow",    overflow,    exp_ovf);
         check_val("busy",        busy,        exp_busy);
      end
   end

   // ---------------- stimulus helpers ----------------
   bit toggle_mode = 1'b0;

   task automatic step();
      @(posedge clk);
      #2;
      if (toggle_mode) sig_in = ~sig_in;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Steps until count_valid is seen in the current cycle or budget expires.
   task automatic wait_valid(input string tag, input int budget, output int waited);
      bit seen;
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < budget) begin
         if (count_valid === 1'b1) seen = 1'b1;
         else begin
            step();
            waited++;
         end
      end
      if (!seen && count_valid === 1'b1) seen = 1'b1;
      check_val({tag, "_seen"}, 32'(seen), 32'd1);
   endtask

   int w;
   int rlen;
   int dens;
   bit saw_valid;

   initial begin
      rst = 1'b1; en = 1'b0; sig_in = 1'b1; gate_len = 16'd8;

      // Reset with sig_in held high: no false edge in the first window.
      steps(3);
      rst = 1'b0;
      steps(6);
      en = 1'b1; gate_len = 16'd8;
      steps(8);
      en = 1'b0;
      wait_valid("hi_thru_rst", 20, w);
      check_val("hi_thru_rst_count", count_out, 0);
      check_val("hi_thru_rst_ovf", overflow, 0);
      steps(3);

      // Period-2 input, gate 10, continuous.
      sig_in = 1'b0; toggle_mode = 1'b1;
      steps(4);
      en = 1'b1; gate_len = 16'd10;
      wait_valid("p2_first", 40, w);
      check_val("p2_first_latency", w, 11);
      check_val("p2_count", count_out, 5);
      check_val("p2_ovf", overflow, 0);
      step();
      wait_valid("p2_second", 40, w);
      check_val("p2_period", w + 1, 10);
      check_val("p2_count2", count_out, 5);

      // Saturation then recovery; gate change mid-window must not apply early.
      gate_len = 16'd1000;
      step();
      wait_valid("sat_pre", 40, w);
      gate_len = 16'd20;
      step();
      wait_valid("sat", 1100, w);
      check_val("sat_len", w + 1, 1000);
      check_val("sat_count", count_out, 255);
      check_val("sat_ovf", overflow, 1);
      step();
      wait_valid("post_sat", 40, w);
      check_val("post_sat_len", w + 1, 20);
      check_val("post_sat_count", count_out, 10);
      check_val("post_sat_ovf", overflow, 0);
      en = 1'b0; toggle_mode = 1'b0; sig_in = 1'b0;
      steps(25);

      // Zero gate: single detection lands in the only MEASURE cycle.
      sig_in = 1'b1; step();
      en = 1'b1; gate_len = 16'd0; step();
      en = 1'b0; step();
      check_val("gate0_valid", count_valid, 1);
      check_val("gate0_count", count_out, 1);
      check_val("gate0_busy", busy, 0);
      sig_in = 1'b0; steps(5);

      // Gate 4 with the detection on the 4th (final) window cycle.
      en = 1'b1; gate_len = 16'd4; step();
      step();
      sig_in = 1'b1; step();
      step();
      en = 1'b0; step();
      check_val("gate4_valid", count_valid, 1);
      check_val("gate4_count", count_out, 1);
      sig_in = 1'b0; steps(5);

      // Abort after 5 MEASURE cycles holding 2 edges.
      sig_in = 1'b1; step();
      sig_in = 1'b0; en = 1'b1; gate_len = 16'd10; step();
      sig_in = 1'b1; step();
      sig_in = 1'b0; steps(4);
      en = 1'b0; step();
      check_val("abort_busy", busy, 0);
      saw_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (count_valid === 1'b1) saw_valid = 1'b1;
         step();
      end
      check_val("abort_no_valid", 32'(saw_valid), 0);
      check_val("abort_count_held", count_out, 1);

      // Reset mid-window: outputs clear, PRIME holds off en for 3 cycles.
      en = 1'b1; gate_len = 16'd8; toggle_mode = 1'b1;
      steps(4);
      check_val("pre_rst_busy", busy, 1);
      rst = 1'b1; step();
      rst = 1'b0;
      check_val("rst_count", count_out, 0);
      check_val("rst_ovf", overflow, 0);
      check_val("rst_valid", count_valid, 0);
      check_val("rst_busy", busy, 0);
      w = 0;
      while (busy !== 1'b1 && w < 20) begin
         step();
         w++;
      end
      check_val("prime_to_busy", w, PRIME + 1);
      en = 1'b0; toggle_mode = 1'b0;
      steps(20);

      // Random traffic.
      for (int r = 0; r < 40; r++) begin
         rlen = $urandom_range(10, 80);
         dens = $urandom_range(0, 3);
         en   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) gate_len = 16'($urandom_range(13, 300));
         else                           gate_len = 16'($urandom_range(0, 12));
         for (int i = 0; i < rlen; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0) gate_len = 16'($urandom_range(0, 12));
            case (dens)
               0:       sig_in = 1'($urandom_range(0, 1));
               1:       sig_in = ~sig_in;
               2:       if ($urandom_range(0, 4) == 0) sig_in = ~sig_in;
               default: sig_in = sig_in;
            endcase
            step();
         end
      end
      rst = 1'b0; en = 1'b0;
      steps(20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
